// File: rtl/mem_pkg.sv
// Shared definitions for the memory streamer slice.
//   state_t            : burst controller states (IDLE / FETCH / DRAIN)
//   DEFAULT_ADDR_WIDTH : default read address width
//   DEFAULT_DATA_WIDTH : default read / stream data width
//   DEFAULT_FIFO_DEPTH : default output buffer depth
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_FIFO_DEPTH = 2;

endpackage : mem_pkg

// File: rtl/mem_streamer_if.sv
// Bus bundle between the streamer, its synchronous-read memory and the
// stream consumer.
//   read_addr : address to the memory (streamer -> memory)
//   read_data : memory data, one cycle after the address (memory -> streamer)
//   out_valid : stream byte valid (streamer -> consumer)
//   out_ready : consumer ready (consumer -> streamer)
//   out_data  : stream byte (streamer -> consumer)
// Modports: master = streamer side, slave = memory/consumer side.
interface mem_streamer_if
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output read_addr,
        input  read_data,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport slave (
        input  read_addr,
        output read_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );

endinterface : mem_streamer_if

// File: rtl/stream_fifo.sv
// Small circular output buffer for the streamer.
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset (empties the buffer)
//   push      : write push_data this cycle
//   push_data : data to write
//   pop       : discard the head entry this cycle
//   count     : number of stored entries
//   head      : oldest entry (meaningful while count != 0)
// Push and pop in the same cycle are legal when full or empty; the caller
// guarantees it never pushes into a full buffer without popping.
module stream_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

    // Storage carries no reset; validity is tracked by count_reg alone.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

endmodule : stream_fifo

// File: rtl/mem_streamer.sv
// Burst reader: fetches `length` bytes starting at `base_addr` from a
// synchronous-read memory and streams them out over a valid/ready port.
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset
//   start     : begin a burst (only looked at while idle)
//   base_addr : first address, captured with start
//   length    : byte count, captured with start (0 -> immediate done)
//   busy      : high while not idle
//   done      : one-cycle completion pulse
//   bus       : memory read port and output stream (master side)
module mem_streamer
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    output logic                  busy,
    output logic                  done,
    mem_streamer_if.master        bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic [ADDR_WIDTH-1:0] len_reg;
    logic [ADDR_WIDTH-1:0] issued_reg;
    logic [ADDR_WIDTH-1:0] addr_hold_reg;
    logic                  inflight_reg;
    logic                  done_zero_reg;

    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        occupancy;
    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic                  drain_done;

    assign pop = bus.out_valid & bus.out_ready;

    // Slots already committed (buffered + one read in the memory pipeline).
    // A slot freed by this cycle's pop can be reused immediately, which is
    // what keeps the stream at one byte per cycle with only two entries.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
    assign issue     = (state_reg == FETCH) &&
                       (occupancy < DEPTH_C + {{CNT_W{1'b0}}, pop});

    assign last_issue = (issued_reg == len_reg - ADDR_WIDTH'(1));

    // The final byte is the one leaving with nothing behind it in the buffer
    // or the memory pipeline; all addresses are already issued in DRAIN.
    assign drain_done = (state_reg == DRAIN) && pop &&
                        (fifo_count == CNT_W'(1)) && !inflight_reg;

    // Address wraps naturally through the ADDR_WIDTH-bit adder; outside
    // issuing cycles the last issued address is held so the memory sees a
    // stable bus (its reads are simply not captured).
    assign bus.read_addr = issue ? (base_reg + issued_reg) : addr_hold_reg;

    assign busy = (state_reg != IDLE);
    assign done = done_zero_reg | drain_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            len_reg       <= '0;
            issued_reg    <= '0;
            addr_hold_reg <= '0;
            inflight_reg  <= 1'b0;
            done_zero_reg <= 1'b0;
        end else begin
            done_zero_reg <= 1'b0;
            inflight_reg  <= issue;
            if (issue) begin
                addr_hold_reg <= bus.read_addr;
                issued_reg    <= issued_reg + ADDR_WIDTH'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            base_reg   <= base_addr;
                            len_reg    <= length;
                            issued_reg <= '0;
                            state_reg  <= FETCH;
                        end else begin
                            done_zero_reg <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue && last_issue) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Read data is captured only in the cycle after a real issue, so stale
    // returns (non-issuing cycles, or reads launched before a reset) drop.
    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_reg),
        .push_data (bus.read_data),
        .pop       (pop),
        .count     (fifo_count),
        .head      (bus.out_data)
    );

    assign bus.out_valid = (fifo_count != '0);

endmodule : mem_streamer

// File: tb/tb_mem_streamer.sv
module tb_mem_streamer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;

    mem_streamer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

    mem_streamer #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int max_occ      = 0;
    logic [7:0]  exp_q [$];
    logic [15:0] addr_log [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read memory model: mem[i] = i + 0x10
    always @(posedge clock) begin
        bus.read_data <= 8'(bus.read_addr + 16'h0010);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pop on every accepted byte, done bookkeeping,
    // issued-address log and buffer occupancy high-water mark.
    always @(negedge clock) begin
        logic [7:0] exp_b;
        int occ;
        if (!reset) begin
            if (done) done_cnt++;
            if (dut.issue) addr_log.push_back(bus.read_addr);
            occ = int'(dut.fifo_count) + int'(dut.inflight_reg);
            if (occ > max_occ) max_occ = occ;
            if (bus.out_valid && bus.out_ready) begin
                check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(exp_b));
                    check("done_with_last", 32'(done), 32'(exp_q.size() == 0));
                end
            end
        end
    end

    task automatic start_burst(input logic [15:0] b, input logic [15:0] n, input bit expect_data);
        logic [15:0] a;
        @(posedge clock); #1;
        start     = 1'b1;
        base_addr = b;
        length    = n;
        if (expect_data) begin
            for (int i = 0; i < int'(n); i++) begin
                a = b + 16'(i);
                exp_q.push_back(8'(a + 16'h0010));
            end
        end
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(busy || exp_q.size() != 0), 32'd0);
    endtask

    initial begin
        int d0;
        int n;
        reset         = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        length        = '0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_read_addr", 32'(bus.read_addr), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Basic burst: 0x13..0x16 back to back, first valid two cycles in
        d0 = done_cnt;
        start_burst(16'h0003, 16'd4, 1'b1);
        @(negedge clock);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_lat1", 32'(bus.out_valid), 32'd0);
        @(negedge clock);
        check("basic_lat2", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("basic_stream", 32'(bus.out_valid), 32'd1);
        end
        @(negedge clock);
        check("basic_busy_after", 32'(busy), 32'd0);
        check("basic_queue_empty", 32'(exp_q.size()), 32'd0);
        check("basic_done_count", 32'(done_cnt - d0), 32'd1);
        $display("[TB] basic burst base=0x0003 len=4 complete");

        // Backpressure: ready toggles every cycle
        d0      = done_cnt;
        max_occ = 0;
        start_burst(16'h0000, 16'd8, 1'b1);
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 80) begin
            @(posedge clock); #1;
            bus.out_ready = ~bus.out_ready;
            n++;
        end
        @(negedge clock);
        check("bp_complete", 32'(busy || exp_q.size() != 0), 32'd0);
        check("bp_max_occupancy", 32'(max_occ <= 2), 32'd1);
        check("bp_done_count", 32'(done_cnt - d0), 32'd1);
        bus.out_ready = 1'b1;
        $display("[TB] backpressure burst base=0x0000 len=8 complete, max occupancy %0d", max_occ);

        // Address wrap-around
        addr_log.delete();
        start_burst(16'hFFFE, 16'd3, 1'b1);
        wait_idle("wrap_complete", 40);
        check("wrap_addr_count", 32'(addr_log.size()), 32'd3);
        if (addr_log.size() == 3) begin
            check("wrap_addr0", 32'(addr_log[0]), 32'h0000FFFE);
            check("wrap_addr1", 32'(addr_log[1]), 32'h0000FFFF);
            check("wrap_addr2", 32'(addr_log[2]), 32'h00000000);
        end
        $display("[TB] wrap burst base=0xFFFE len=3 complete");

        // Zero-length start
        d0 = done_cnt;
        start_burst(16'h1234, 16'd0, 1'b0);
        @(negedge clock);
        check("zero_done_pulse", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("zero_no_valid", 32'(bus.out_valid), 32'd0);
            check("zero_busy_low", 32'(busy), 32'd0);
        end
        check("zero_done_count", 32'(done_cnt - d0), 32'd1);
        $display("[TB] zero-length start complete");

        // Reset in the middle of a burst while a byte is waiting
        bus.out_ready = 1'b0;
        start_burst(16'h0020, 16'd8, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("midrst_valid_seen", 32'(bus.out_valid), 32'd1);
        check("midrst_busy_before", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_read_addr", 32'(bus.read_addr), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        start_burst(16'h0040, 16'd3, 1'b1);
        wait_idle("midrst_next_burst", 40);
        $display("[TB] reset mid-burst and follow-up burst base=0x0040 len=3 complete");

        // Start while busy is ignored
        d0 = done_cnt;
        start_burst(16'h0050, 16'd4, 1'b1);
        @(posedge clock); #1;
        start     = 1'b1;
        base_addr = 16'h0080;
        length    = 16'd5;
        @(posedge clock); #1;
        start = 1'b0;
        wait_idle("busy_start_complete", 40);
        repeat (8) @(negedge clock);
        check("busy_start_idle", 32'(busy), 32'd0);
        check("busy_start_done_count", 32'(done_cnt - d0), 32'd1);
        $display("[TB] start-while-busy burst base=0x0050 len=4 complete");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_mem_streamer
